route_compute_stage: RTL

//  Registered, packet-aware route computation stage for one router input port of the 2D-mesh NoC.

---
 rtl/route_compute_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/route_compute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// route_compute_stage : XY/YX route computation with per-packet route locking
//                       and a one-entry valid/ready output register.
// Revision 1.0
// ----------------------------------------------------------------------------
module route_compute_stage #(
    parameter int x_Current       = 3,
    parameter int y_Current       = 3,
    parameter int x_Des_Addr_Size = 5,
    parameter int y_Des_Addr_Size = 5,
    parameter int MESH_X          = 8,
    parameter int MESH_Y          = 8,
    parameter int FLIT_DATA_W     = 32,
    parameter int ALGO            = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_type,
    input  logic [FLIT_DATA_W-1:0]     in_data,
    input  logic [x_Des_Addr_Size-1:0] x_Dest,
    input  logic [y_Des_Addr_Size-1:0] y_Dest,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_type,
    output logic [FLIT_DATA_W-1:0]     out_data,
    output logic [2:0]                 port,
    output logic                       dest_err,
    output logic                       proto_err
);

    localparam int XW = x_Des_Addr_Size + 1;
    localparam int YW = y_Des_Addr_Size + 1;

    localparam logic [2:0] c_LOCAL = 3'd0;
    localparam logic [2:0] c_NORTH = 3'd1;
    localparam logic [2:0] c_EAST  = 3'd2;
    localparam logic [2:0] c_SOUTH = 3'd3;
    localparam logic [2:0] c_WEST  = 3'd4;

    localparam logic [1:0] c_HEAD     = 2'b00;
    localparam logic [1:0] c_BODY     = 2'b01;
    localparam logic [1:0] c_TAIL     = 2'b10;
    localparam logic [1:0] c_HEADTAIL = 2'b11;

    // One extra bit so the mesh-size bounds are representable next to the dest fields.
    localparam logic [XW-1:0] c_X_CUR  = XW'(x_Current);
    localparam logic [YW-1:0] c_Y_CUR  = YW'(y_Current);
    localparam logic [XW-1:0] c_MESH_X = XW'(MESH_X);
    localparam logic [YW-1:0] c_MESH_Y = YW'(MESH_Y);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_PACKET = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             lock_q, lock_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             out_type_q, out_type_d;
    logic [FLIT_DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]             port_q, port_d;
    logic                   dest_err_q, dest_err_d;
    logic                   proto_err_q, proto_err_d;

    logic [XW-1:0] w_x_ext;
    logic [YW-1:0] w_y_ext;
    logic          w_dest_bad;
    logic [2:0]    w_x_route;
    logic [2:0]    w_y_route;
    logic [2:0]    w_route;
    logic          w_accept;
    logic          w_is_head;
    logic          w_fwd;
    logic [2:0]    w_fwd_route;

    assign w_x_ext = {1'b0, x_Dest};
    assign w_y_ext = {1'b0, y_Dest};

    always_comb begin
        w_dest_bad = (w_x_ext >= c_MESH_X) || (w_y_ext >= c_MESH_Y);
        w_x_route  = (w_x_ext < c_X_CUR) ? c_WEST :
                     (w_x_ext > c_X_CUR) ? c_EAST : c_LOCAL;
        w_y_route  = (w_y_ext < c_Y_CUR) ? c_NORTH :
                     (w_y_ext > c_Y_CUR) ? c_SOUTH : c_LOCAL;
        if (w_dest_bad) begin
            w_route = c_LOCAL;
        end else if (ALGO == 0) begin
            w_route = (w_x_route != c_LOCAL) ? w_x_route : w_y_route;
        end else begin
            w_route = (w_y_route != c_LOCAL) ? w_y_route : w_x_route;
        end
    end

    assign in_ready  = !out_valid_q || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_is_head = (in_type == c_HEAD) || (in_type == c_HEADTAIL);

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_data_d  = out_data_q;
        port_d      = port_q;
        dest_err_d  = 1'b0;
        proto_err_d = 1'b0;
        w_fwd       = 1'b0;
        w_fwd_route = lock_q;

        if (in_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_is_head) begin
                // A head arriving mid-packet abandons the old packet and starts a new one.
                w_fwd       = 1'b1;
                w_fwd_route = w_route;
                dest_err_d  = w_dest_bad;
                proto_err_d = (state_q == S_PACKET);
                if (in_type == c_HEAD) begin
                    lock_d  = w_route;
                    state_d = S_PACKET;
                end else begin
                    state_d = S_IDLE;
                end
            end else if (state_q == S_PACKET) begin
                w_fwd = 1'b1;
                if (in_type == c_TAIL) begin
                    state_d = S_IDLE;
                end
            end else begin
                proto_err_d = 1'b1;
            end

            if (w_fwd) begin
                out_valid_d = 1'b1;
                out_type_d  = in_type;
                out_data_d  = in_data;
                port_d      = w_fwd_route;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lock_q      <= c_LOCAL;
            out_valid_q <= 1'b0;
            out_type_q  <= 2'b00;
            out_data_q  <= '0;
            port_q      <= c_LOCAL;
            dest_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_data_q  <= out_data_d;
            port_q      <= port_d;
            dest_err_q  <= dest_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_data  = out_data_q;
    assign port      = port_q;
    assign dest_err  = dest_err_q;
    assign proto_err = proto_err_q;

    // Body flit type is only distinguished implicitly (non-head, non-tail).
    logic w_unused_body;
    assign w_unused_body = (in_type == c_BODY);

endmodule
`default_nettype wire
